window_col_gen: RTL and testbench

Parametrised vertical window-column generator for the spatial filter pipeline. It buffers 2K = MASK_WIDTH−1 image rows and emits one MASK_WIDTH-tall pixel column per output beat. Rows beyond the top and bottom borders are mirrored without duplicating the edge row. It tracks frame position internally, honours an input valid/ready handshake, and self-flushes the last K rows at end of frame. Its output feeds the horizontal window/kernel stage.

---
 rtl/window_col_gen.sv | 152 +++++++++++++++
 tb/tb_window_col_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_col_gen.sv
// Vertical window-column generator: buffers 2K image rows and emits one
// MASK_WIDTH-tall pixel column per output beat. Rows beyond the top and
// bottom frame borders are mirrored without repeating the edge row. The
// last K rows are produced by an internal flush at end of frame.
module window_col_gen #(
  parameter int ROW_WIDTH  = 340,
  parameter int IMG_ROWS   = 240,
  parameter int PIX_BIT    = 8,
  parameter int MASK_WIDTH = 7
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [PIX_BIT-1:0]                pix_in,
  input  logic                              pix_in_valid,
  output logic                              pix_in_ready,
  input  logic                              frame_abort,
  output logic [PIX_BIT*MASK_WIDTH-1:0]     col_out,
  output logic                              col_out_valid,
  output logic [$clog2(IMG_ROWS)-1:0]       out_row,
  output logic [$clog2(ROW_WIDTH)-1:0]      out_col,
  output logic                              frame_done
);

  localparam int K     = (MASK_WIDTH - 1) / 2;
  localparam int DEPTH = 2 * K * ROW_WIDTH;
  localparam int CW    = $clog2(ROW_WIDTH);
  localparam int RW    = $clog2(IMG_ROWS + K);
  localparam int OW    = $clog2(IMG_ROWS);

  typedef enum logic [1:0] {
    S_PRIME,
    S_STREAM,
    S_FLUSH
  } state_t;

  state_t                          state;
  logic [CW-1:0]                   in_col;
  logic [RW-1:0]                   in_row;   // virtual rows >= IMG_ROWS only during flush
  logic                            accept;
  logic                            step;
  logic                            advance;
  logic                            col_last;
  logic                            stream_last;
  logic                            flush_last;
  logic [PIX_BIT-1:0]              shift_in;
  logic [PIX_BIT-1:0]              sr [DEPTH];     // 2K rows laid end to end, sr[0] newest
  logic [PIX_BIT-1:0]              row_tap [2*K+1]; // row_tap[j]: current column, j rows older
  logic [PIX_BIT*MASK_WIDTH-1:0]   col_next;

  // Reflect a row index about the first/last image row (edge row not repeated).
  function automatic int mirror_row(input int q);
    if (q < 0)                  return -q;
    else if (q > IMG_ROWS - 1)  return 2 * (IMG_ROWS - 1) - q;
    else                        return q;
  endfunction

  assign accept      = pix_in_valid & pix_in_ready;
  assign step        = accept | (state == S_FLUSH);
  assign advance     = step & ~frame_abort;
  assign shift_in    = (state == S_FLUSH) ? '0 : pix_in;
  assign col_last    = (in_col == CW'(ROW_WIDTH - 1));
  assign stream_last = col_last & (in_row == RW'(IMG_ROWS - 1));
  assign flush_last  = col_last & (in_row == RW'(IMG_ROWS + K - 1));

  // Same-column pixel of every resident row: the incoming one plus each buffer's oldest entry.
  always_comb begin
    row_tap[0] = shift_in;
    for (int j = 1; j <= 2 * K; j++) row_tap[j] = sr[j*ROW_WIDTH-1];
  end

  // Pick, for each tap, the resident row that the mirrored tap row maps to.
  always_comb begin
    // NOTE: default first so every path assigns col_next and no latch is inferred.
    col_next = '0;
    for (int t = 0; t < MASK_WIDTH; t++) begin
      for (int j = 0; j <= 2 * K; j++) begin
        if (int'(in_row) - mirror_row(int'(in_row) - t) == j)
          col_next[t*PIX_BIT +: PIX_BIT] = row_tap[j];
      end
    end
  end

  // Row buffer chain: advances one pixel per accept or flush cycle.
  // NOTE: pure data storage, deliberately not reset; priming overwrites it before use.
  always_ff @(posedge clk) begin
    if (advance) begin
      sr[0] <= shift_in;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  // Frame-position FSM with registered column outputs and handshake.
  // NOTE: non-blocking assignments throughout, so every read sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_PRIME;
      in_col        <= '0;
      in_row        <= '0;
      pix_in_ready  <= 1'b0;
      col_out       <= '0;
      col_out_valid <= 1'b0;
      out_row       <= '0;
      out_col       <= '0;
      frame_done    <= 1'b0;
    end else begin
      col_out_valid <= 1'b0;
      frame_done    <= 1'b0;
      pix_in_ready  <= (state != S_FLUSH);
      if (frame_abort) begin
        state        <= S_PRIME;
        in_col       <= '0;
        in_row       <= '0;
        pix_in_ready <= 1'b1;
      end else if (step) begin
        if (state != S_PRIME) begin
          col_out       <= col_next;
          out_row       <= OW'(in_row - RW'(K));
          out_col       <= in_col;
          col_out_valid <= 1'b1;
        end
        if (col_last) begin
          in_col <= '0;
          in_row <= in_row + RW'(1);
        end else begin
          in_col <= in_col + CW'(1);
        end
        case (state)
          S_PRIME: begin
            if (col_last && in_row == RW'(K - 1)) state <= S_STREAM;
          end
          S_STREAM: begin
            if (stream_last) begin
              state        <= S_FLUSH;
              pix_in_ready <= 1'b0;
            end
          end
          S_FLUSH: begin
            if (flush_last) begin
              state        <= S_PRIME;
              in_col       <= '0;
              in_row       <= '0;
              pix_in_ready <= 1'b1;
              frame_done   <= 1'b1;
            end
          end
          default: state <= S_PRIME;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_col_gen.sv
// Self-checking bench for window_col_gen: two instances (M=3 4x4, M=5 4x3)
// driven with raster frames, random valid gaps, back-to-back frames, async
// reset and frame_abort, against a frame-image reference model.
module tb_window_col_gen;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        valid [2];
  logic [7:0]  pix   [2];
  logic        abort [2];

  logic        rdy_a, colv_a, done_a;
  logic [23:0] col_a;
  logic [1:0]  orow_a, ocol_a;
  logic        rdy_b, colv_b, done_b;
  logic [39:0] col_b;
  logic [1:0]  orow_b, ocol_b;

  always #5 clk = ~clk;

  window_col_gen #(.ROW_WIDTH(4), .IMG_ROWS(4), .PIX_BIT(8), .MASK_WIDTH(3)) dut_a (
    .clk(clk), .reset(rst[0]), .pix_in(pix[0]), .pix_in_valid(valid[0]),
    .pix_in_ready(rdy_a), .frame_abort(abort[0]), .col_out(col_a),
    .col_out_valid(colv_a), .out_row(orow_a), .out_col(ocol_a), .frame_done(done_a)
  );

  window_col_gen #(.ROW_WIDTH(4), .IMG_ROWS(3), .PIX_BIT(8), .MASK_WIDTH(5)) dut_b (
    .clk(clk), .reset(rst[1]), .pix_in(pix[1]), .pix_in_valid(valid[1]),
    .pix_in_ready(rdy_b), .frame_abort(abort[1]), .col_out(col_b),
    .col_out_valid(colv_b), .out_row(orow_b), .out_col(ocol_b), .frame_done(done_b)
  );

  // Instance geometry
  function automatic int k_of(input int i); return (i == 0) ? 1 : 2; endfunction
  function automatic int n_of(input int i); return (i == 0) ? 4 : 3; endfunction
  function automatic int w_of(input int i); return 4; endfunction
  function automatic string nm(input int i, input string s);
    return $sformatf("%s.%s", (i == 0) ? "a" : "b", s);
  endfunction

  // DUT output accessors
  function automatic logic [63:0] o_col(input int i);
    return (i == 0) ? 64'(col_a) : 64'(col_b);
  endfunction
  function automatic logic o_rdy(input int i);  return (i == 0) ? rdy_a  : rdy_b;  endfunction
  function automatic logic o_colv(input int i); return (i == 0) ? colv_a : colv_b; endfunction
  function automatic logic o_done(input int i); return (i == 0) ? done_a : done_b; endfunction
  function automatic int o_row(input int i);  return (i == 0) ? int'(orow_a) : int'(orow_b); endfunction
  function automatic int o_cidx(input int i); return (i == 0) ? int'(ocol_a) : int'(ocol_b); endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: full frame image plus position counters
  int          img [2][8][8];
  int          m_n [2];
  int          m_f [2];
  bit          m_fl [2];
  bit          m_rdy [2];
  bit          e_v [2];
  bit          e_done [2];
  logic [63:0] e_col [2];
  int          e_row [2];
  int          e_c [2];

  // Observation bookkeeping
  logic [63:0] cap  [2][8][8];
  logic [63:0] cont [8][8];
  int          ncols [2];
  int          ndone [2];
  int          run [2];
  int          last_run [2];

  // Window column for centre row r, column c, straight from the frame image.
  task automatic set_exp(input int i, input int r, input int c);
    int k, n, q;
    logic [63:0] v;
    k = k_of(i);
    n = n_of(i);
    v = '0;
    for (int t = 0; t <= 2 * k; t++) begin
      q = r + k - t;
      if (q < 0) q = -q;
      else if (q > n - 1) q = 2 * (n - 1) - q;
      v = v | (64'(img[i][q][c] & 255) << (8 * t));
    end
    e_v[i]   = 1'b1;
    e_col[i] = v;
    e_row[i] = r;
    e_c[i]   = c;
  endtask

  task automatic model_step(input int i);
    int k, n, w, rr, cc;
    k = k_of(i); n = n_of(i); w = w_of(i);
    e_v[i] = 1'b0;
    e_done[i] = 1'b0;
    if (rst[i]) begin
      m_n[i] = 0; m_f[i] = 0; m_fl[i] = 1'b0; m_rdy[i] = 1'b0;
      ncols[i] = 0; run[i] = 0;
    end else if (abort[i]) begin
      m_n[i] = 0; m_fl[i] = 1'b0; ncols[i] = 0;
    end else if (m_fl[i]) begin
      rr = n + m_f[i] / w;
      cc = m_f[i] % w;
      set_exp(i, rr - k, cc);
      m_f[i]++;
      if (m_f[i] == k * w) begin
        e_done[i] = 1'b1;
        m_fl[i] = 1'b0;
        m_n[i] = 0;
      end
    end else if (valid[i] && m_rdy[i]) begin
      rr = m_n[i] / w;
      cc = m_n[i] % w;
      img[i][rr][cc] = int'(pix[i]);
      if (rr >= k) set_exp(i, rr - k, cc);
      m_n[i]++;
      if (m_n[i] == n * w) begin
        m_fl[i] = 1'b1;
        m_f[i] = 0;
      end
    end
    if (!rst[i]) m_rdy[i] = !m_fl[i];
  endtask

  task automatic compare(input int i);
    if (rst[i]) return;
    check(nm(i, "ready"), 64'(o_rdy(i)), 64'(m_rdy[i]));
    check(nm(i, "col_valid"), 64'(o_colv(i)), 64'(e_v[i]));
    check(nm(i, "frame_done"), 64'(o_done(i)), 64'(e_done[i]));
    if (e_v[i]) begin
      check(nm(i, "col_out"), o_col(i), e_col[i]);
      check(nm(i, "out_row"), 64'(o_row(i)), 64'(e_row[i]));
      check(nm(i, "out_col"), 64'(o_cidx(i)), 64'(e_c[i]));
    end
    if (o_colv(i)) begin
      cap[i][o_row(i)][o_cidx(i)] = o_col(i);
      ncols[i]++;
    end
    if (o_done(i)) begin
      ndone[i]++;
      check(nm(i, "cols_per_frame"), 64'(ncols[i]), 64'(n_of(i) * w_of(i)));
      check(nm(i, "done_row"), 64'(o_row(i)), 64'(n_of(i) - 1));
      check(nm(i, "done_col"), 64'(o_cidx(i)), 64'(w_of(i) - 1));
      ncols[i] = 0;
    end
    if (!o_rdy(i)) run[i]++;
    else begin
      if (run[i] > 0) last_run[i] = run[i];
      run[i] = 0;
    end
  endtask

  // Model advances on each edge; DUT outputs are compared 1 time unit later.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) compare(i);
  end

  function automatic logic [7:0] pixval(input int kind, input int n, input int w);
    case (kind)
      0:       return 8'(16 * (n / w) + n % w);
      1:       return 8'(8'h80 + 16 * (n / w) + n % w);
      default: return 8'($urandom_range(255));
    endcase
  endfunction

  // Present `count` raster pixels; gap_pct is the chance of an idle cycle.
  task automatic send(input int i, input int kind, input int count, input int gap_pct);
    int n, waited;
    logic v;
    n = 0;
    waited = 0;
    while (n < count) begin
      @(negedge clk);
      v = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
      valid[i] = v;
      pix[i]   = pixval(kind, n, w_of(i));
      if (v && o_rdy(i)) begin
        n++;
        waited = 0;
      end else begin
        waited++;
        if (waited > 100) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s: no accept within 100 cycles at pixel %0d", nm(i, "handshake"), n);
          return;
        end
      end
    end
  endtask

  task automatic idle(input int i, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      valid[i] = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input int i, input string tag);
    check(nm(i, {tag, ".col_out"}), o_col(i), 64'h0);
    check(nm(i, {tag, ".col_valid"}), 64'(o_colv(i)), 64'h0);
    check(nm(i, {tag, ".out_row"}), 64'(o_row(i)), 64'h0);
    check(nm(i, {tag, ".out_col"}), 64'(o_cidx(i)), 64'h0);
    check(nm(i, {tag, ".frame_done"}), 64'(o_done(i)), 64'h0);
    check(nm(i, {tag, ".ready"}), 64'(o_rdy(i)), 64'h0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; valid[i] = 1'b0; pix[i] = '0; abort[i] = 1'b0;
      ncols[i] = 0; ndone[i] = 0; run[i] = 0; last_run[i] = 0;
      m_n[i] = 0; m_f[i] = 0; m_fl[i] = 1'b0; m_rdy[i] = 1'b0;
    end
    #2;
    check_reset_outputs(0, "por");
    check_reset_outputs(1, "por");
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Continuous 4x4 M=3 frame with pixel = 16*row+col
    send(0, 0, 16, 0);
    idle(0, 8);
    check("a.lit_r0c0", cap[0][0][0], 64'h100010);
    check("a.lit_r0c1", cap[0][0][1], 64'h110111);
    check("a.lit_r3c0", cap[0][3][0], 64'h203020);
    check("a.lit_r3c3", cap[0][3][3], 64'h233323);
    check("a.flush_len", 64'(last_run[0]), 64'd4);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) cont[r][c] = cap[0][r][c];

    // Same frame with ~50% valid gaps: identical column set
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) cap[0][r][c] = '0;
    send(0, 0, 16, 50);
    idle(0, 8);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check($sformatf("a.gap_r%0dc%0d", r, c), cap[0][r][c], cont[r][c]);

    // Back-to-back frames: 0x80-based data, then the golden pattern
    send(0, 1, 16, 0);
    send(0, 0, 16, 0);
    idle(0, 8);
    for (int c = 0; c < 4; c++)
      check($sformatf("a.b2b_r0c%0d", c), cap[0][0][c], cont[0][c]);

    // M=5, 4 wide, 3 rows: double mirroring at both borders
    send(1, 0, 12, 0);
    idle(1, 12);
    check("b.lit_r0c0", cap[1][0][0], 64'h2010001020);
    check("b.lit_r2c0", cap[1][2][0], 64'h0010201000);
    check("b.flush_len", 64'(last_run[1]), 64'd8);
    send(1, 2, 12, 30);
    idle(1, 12);

    // Random data with random gaps on the M=3 instance
    send(0, 2, 16, 40);
    idle(0, 8);

    // Asynchronous reset part-way through row 2
    send(0, 0, 9, 0);
    @(negedge clk);
    valid[0] = 1'b0;
    #2;
    rst[0] = 1'b1;
    #1;
    check_reset_outputs(0, "async");
    @(negedge clk);
    rst[0] = 1'b0;

    // frame_abort part-way through row 1, then a clean golden frame
    send(0, 0, 6, 0);
    @(negedge clk);
    valid[0] = 1'b0;
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) cap[0][r][c] = '0;
    send(0, 0, 16, 0);
    idle(0, 8);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check($sformatf("a.post_abort_r%0dc%0d", r, c), cap[0][r][c], cont[r][c]);

    check("a.frames_done", 64'(ndone[0]), 64'd6);
    check("b.frames_done", 64'(ndone[1]), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
